// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: lets two requesters share one combinational ALU.
// Each cycle the arbiter picks a requester, steers its op onto the ALU and
// captures the ALU result/zero flag into a one-entry tagged response register.
module alu_share_arbiter #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned OPSEL_W = 4,
  parameter int unsigned RR_EN   = 1
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_req0_valid,
  output logic               o_req0_ready,
  input  logic [OPSEL_W-1:0] i_req0_opsel,
  input  logic [XLEN-1:0]    i_req0_op1,
  input  logic [XLEN-1:0]    i_req0_op2,
  input  logic               i_req1_valid,
  output logic               o_req1_ready,
  input  logic [OPSEL_W-1:0] i_req1_opsel,
  input  logic [XLEN-1:0]    i_req1_op1,
  input  logic [XLEN-1:0]    i_req1_op2,
  output logic [OPSEL_W-1:0] o_alu_opsel,
  output logic [XLEN-1:0]    o_alu_op1,
  output logic [XLEN-1:0]    o_alu_op2,
  input  logic [XLEN-1:0]    i_alu_result,
  input  logic               i_alu_zero,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic               o_rsp_id,
  output logic [XLEN-1:0]    o_rsp_result,
  output logic               o_rsp_zero
);

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]      state_q;
  logic [0:0]      state_d;
  logic            held_id_q;
  logic            held_id_d;
  logic            last_grant_q;
  logic            grant_id_c;
  logic            grant_vld_c;
  logic            space_c;
  logic            accept_c;

  logic            rsp_valid_q;
  logic            rsp_id_q;
  logic [XLEN-1:0] rsp_result_q;
  logic            rsp_zero_q;

  // Arbitration, next state and requester readies.
  always_comb begin
    state_d     = state_q;
    held_id_d   = held_id_q;
    grant_id_c  = 1'b0;
    grant_vld_c = 1'b0;
    // The response slot frees up in the same cycle it is drained.
    space_c     = !rsp_valid_q || i_rsp_ready;
    case (state_q)
      ST_ARB: begin
        grant_vld_c = i_req0_valid || i_req1_valid;
        if (i_req0_valid && i_req1_valid) begin
          grant_id_c = (RR_EN != 0) ? !last_grant_q : 1'b0;
        end else begin
          grant_id_c = i_req1_valid;
        end
        // Stalled winner keeps its grant so the other side cannot overtake it.
        if (grant_vld_c && !space_c) begin
          state_d   = ST_HOLD;
          held_id_d = grant_id_c;
        end
      end
      ST_HOLD: begin
        grant_id_c  = held_id_q;
        grant_vld_c = held_id_q ? i_req1_valid : i_req0_valid;
        if (grant_vld_c && space_c) begin
          state_d = ST_ARB;
        end
      end
      default: begin
        state_d = ST_ARB;
      end
    endcase
    accept_c     = grant_vld_c && space_c && !i_rst;
    o_req0_ready = accept_c && !grant_id_c;
    o_req1_ready = accept_c && grant_id_c;
  end

  // Steer the granted op to the ALU; idle drives the ALU's default op.
  always_comb begin
    o_alu_opsel = {OPSEL_W{1'b1}};
    o_alu_op1   = '0;
    o_alu_op2   = '0;
    if (grant_vld_c) begin
      if (grant_id_c) begin
        o_alu_opsel = i_req1_opsel;
        o_alu_op1   = i_req1_op1;
        o_alu_op2   = i_req1_op2;
      end else begin
        o_alu_opsel = i_req0_opsel;
        o_alu_op1   = i_req0_op1;
        o_alu_op2   = i_req0_op2;
      end
    end
  end

  // Arbiter state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_ARB;
    end else begin
      state_q <= state_d;
    end
  end

  // Held grant and round-robin history; reset leaves req0 as next winner.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      held_id_q    <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      held_id_q <= held_id_d;
      if (accept_c) begin
        last_grant_q <= grant_id_c;
      end
    end
  end

  // One-entry response register; contents hold while full and not taken.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else if (accept_c) begin
      rsp_valid_q  <= 1'b1;
      rsp_id_q     <= grant_id_c;
      rsp_result_q <= i_alu_result;
      rsp_zero_q   <= i_alu_zero;
    end else if (i_rsp_ready) begin
      rsp_valid_q <= 1'b0;
    end
  end

  assign o_rsp_valid  = rsp_valid_q;
  assign o_rsp_id     = rsp_id_q;
  assign o_rsp_result = rsp_result_q;
  assign o_rsp_zero   = rsp_zero_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: two instances (round-robin and fixed priority),
// a behavioural ALU, a per-cycle arbitration model and a response scoreboard.
module tb_alu_share_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v0, v1, rsp_ready;
  logic [3:0]  opsel0, opsel1;
  logic [31:0] a0, b0, a1, b1;
  int          sel;

  logic        v0_g [2];
  logic        v1_g [2];
  logic        rr_g [2];
  logic        rdy0 [2];
  logic        rdy1 [2];
  logic [3:0]  alu_opsel [2];
  logic [31:0] alu_op1 [2];
  logic [31:0] alu_op2 [2];
  logic [32:0] alu_out [2];
  logic        rsp_valid [2];
  logic        rsp_id [2];
  logic [31:0] rsp_result [2];
  logic        rsp_zero [2];

  // Behavioural ALU: returns {zero, result}.
  function automatic logic [32:0] alu_f(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (s)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd4: r = a | b;
      4'd5: r = a ^ b;
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  for (genvar d = 0; d < 2; d++) begin : g_side
    assign v0_g[d]    = v0 && (sel == d);
    assign v1_g[d]    = v1 && (sel == d);
    assign rr_g[d]    = rsp_ready && (sel == d);
    assign alu_out[d] = alu_f(alu_opsel[d], alu_op1[d], alu_op2[d]);
  end

  alu_share_arbiter #(.XLEN(32), .OPSEL_W(4), .RR_EN(1)) dut_rr (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0_g[0]), .o_req0_ready(rdy0[0]), .i_req0_opsel(opsel0), .i_req0_op1(a0), .i_req0_op2(b0),
    .i_req1_valid(v1_g[0]), .o_req1_ready(rdy1[0]), .i_req1_opsel(opsel1), .i_req1_op1(a1), .i_req1_op2(b1),
    .o_alu_opsel(alu_opsel[0]), .o_alu_op1(alu_op1[0]), .o_alu_op2(alu_op2[0]),
    .i_alu_result(alu_out[0][31:0]), .i_alu_zero(alu_out[0][32]),
    .o_rsp_valid(rsp_valid[0]), .i_rsp_ready(rr_g[0]), .o_rsp_id(rsp_id[0]),
    .o_rsp_result(rsp_result[0]), .o_rsp_zero(rsp_zero[0])
  );

  alu_share_arbiter #(.XLEN(32), .OPSEL_W(4), .RR_EN(0)) dut_fp (
    .i_clk(clk), .i_rst(rst),
    .i_req0_valid(v0_g[1]), .o_req0_ready(rdy0[1]), .i_req0_opsel(opsel0), .i_req0_op1(a0), .i_req0_op2(b0),
    .i_req1_valid(v1_g[1]), .o_req1_ready(rdy1[1]), .i_req1_opsel(opsel1), .i_req1_op1(a1), .i_req1_op2(b1),
    .o_alu_opsel(alu_opsel[1]), .o_alu_op1(alu_op1[1]), .o_alu_op2(alu_op2[1]),
    .i_alu_result(alu_out[1][31:0]), .i_alu_zero(alu_out[1][32]),
    .o_rsp_valid(rsp_valid[1]), .i_rsp_ready(rr_g[1]), .o_rsp_id(rsp_id[1]),
    .o_rsp_result(rsp_result[1]), .o_rsp_zero(rsp_zero[1])
  );

  // Outputs of whichever instance is under test.
  logic        r0_a, r1_a, rv_a, rid_a, rz_a;
  logic [31:0] rres_a;
  logic [67:0] alu_a;
  always_comb begin
    r0_a   = rdy0[sel];
    r1_a   = rdy1[sel];
    rv_a   = rsp_valid[sel];
    rid_a  = rsp_id[sel];
    rz_a   = rsp_zero[sel];
    rres_a = rsp_result[sel];
    alu_a  = {alu_opsel[sel], alu_op1[sel], alu_op2[sel]};
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [71:0] got, input logic [71:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Scoreboard: {id, zero, result} in acceptance order.
  logic [33:0] exp_q [$];
  logic [15:0] id_hist;
  int          id_cnt;

  // Reference model state: arbitration history and response occupancy.
  logic m_rr, m_last, m_stick, m_sid, m_full;

  // Monitor: every consumed response is compared against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && rv_a && rsp_ready) begin
        if (exp_q.size() == 0) begin
          chk("rsp_unexpected", {rid_a, rz_a, rres_a}, 72'h3_0000_0000_0);
        end else begin
          chk("rsp", {rid_a, rz_a, rres_a}, exp_q.pop_front());
        end
        id_hist = {id_hist[14:0], rid_a};
        id_cnt++;
      end
    end
  end

  // One clock with the inputs as currently set; requesters drop after acceptance.
  task automatic cycle();
    logic have, win, space, acc0, acc1;
    #1;
    space = !m_full || rsp_ready;
    if (m_stick) begin
      win  = m_sid;
      have = win ? v1 : v0;
    end else begin
      have = v0 || v1;
      if (v0 && v1) win = m_rr ? !m_last : 1'b0;
      else          win = v1;
    end
    chk("ready0", 72'(r0_a), 72'(have && !win && space));
    chk("ready1", 72'(r1_a), 72'(have && win && space));
    chk("rsp_valid", 72'(rv_a), 72'(m_full));
    if (!have) chk("alu_idle", 72'(alu_a), {4'd0, 4'hF, 64'd0});
    if (have && space) begin
      exp_q.push_back({win, win ? alu_f(opsel1, a1, b1) : alu_f(opsel0, a0, b0)});
      m_last  = win;
      m_stick = 1'b0;
      m_full  = 1'b1;
    end else if (have) begin
      m_stick = 1'b1;
      m_sid   = win;
    end else if (rsp_ready) begin
      m_full = 1'b0;
    end
    acc0 = v0 && r0_a;
    acc1 = v1 && r1_a;
    @(negedge clk);
    if (acc0) v0 = 1'b0;
    if (acc1) v1 = 1'b0;
  endtask

  task automatic reset_dut(input bit do_chk);
    rst = 1'b1;
    #1;
    if (do_chk) begin
      chk("rst_rsp_valid", 72'(rv_a), 72'd0);
      chk("rst_ready0", 72'(r0_a), 72'd0);
      chk("rst_ready1", 72'(r1_a), 72'd0);
    end
    @(negedge clk);
    rst     = 1'b0;
    m_last  = 1'b1;
    m_stick = 1'b0;
    m_full  = 1'b0;
    exp_q.delete();
  endtask

  task automatic set0(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    v0 = 1'b1; opsel0 = s; a0 = a; b0 = b;
  endtask

  task automatic set1(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    v1 = 1'b1; opsel1 = s; a1 = a; b1 = b;
  endtask

  function automatic logic [31:0] rnd_val();
    return ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
  endfunction

  function automatic logic [3:0] rnd_op();
    return ($urandom_range(0, 7) == 7) ? 4'hF : 4'($urandom_range(0, 5));
  endfunction

  task automatic clr_hist();
    id_hist = '0;
    id_cnt  = 0;
  endtask

  initial begin
    rst = 1'b1; sel = 0; m_rr = 1'b1;
    v0 = 1'b0; v1 = 1'b0; rsp_ready = 1'b0;
    opsel0 = '0; opsel1 = '0; a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    clr_hist();
    set0(4'd0, 32'd1, 32'd1);
    set1(4'd0, 32'd2, 32'd2);
    repeat (2) @(negedge clk);
    #1;
    chk("reset_rsp", {rv_a, rid_a, rz_a, rres_a}, 72'd0);
    chk("reset_readies", {r0_a, r1_a}, 72'd0);
    @(negedge clk);
    v0 = 1'b0; v1 = 1'b0;
    rst = 1'b0; m_last = 1'b1; m_stick = 1'b0; m_full = 1'b0;

    // Single op: ADD 5,7.
    rsp_ready = 1'b1;
    set0(4'd0, 32'd5, 32'd7);
    cycle();
    chk("single_rsp", {rv_a, rid_a, rz_a, rres_a}, {1'b1, 1'b0, 1'b0, 32'd12});
    cycle();

    // Round robin with both requesters always valid.
    reset_dut(0);
    clr_hist();
    set1(4'd1, 32'd3, 32'd3);
    for (int i = 0; i < 4; i++) begin
      if (!v0) set0(4'd0, 32'd1, 32'd1);
      if (!v1) set1(4'd1, 32'd3, 32'd3);
      cycle();
    end
    v0 = 1'b0; v1 = 1'b0;
    repeat (2) cycle();
    chk("rr_ids", {id_cnt[7:0], id_hist[7:0]}, {8'd4, 8'b0101});

    // Backpressure: stalled req0 keeps its grant over a late req1.
    reset_dut(0);
    rsp_ready = 1'b0;
    set0(4'd0, 32'd10, 32'd20);
    cycle();
    set0(4'd1, 32'd9, 32'd9);
    cycle();
    set1(4'd5, 32'd5, 32'd6);
    repeat (2) cycle();
    chk("hold_stable", {rv_a, rid_a, rz_a, rres_a}, {1'b1, 1'b0, 1'b0, 32'd30});
    clr_hist();
    rsp_ready = 1'b1;
    repeat (4) cycle();
    chk("hold_order", {id_cnt[7:0], id_hist[7:0]}, {8'd3, 8'b001});

    // Drain and refill in the same cycle.
    reset_dut(0);
    rsp_ready = 1'b0;
    set0(4'd0, 32'd2, 32'd2);
    cycle();
    rsp_ready = 1'b1;
    set1(4'd3, 32'hFFFF_FFFF, 32'd0);
    cycle();
    chk("refill_rsp", {rv_a, rid_a, rz_a, rres_a}, {1'b1, 1'b1, 1'b0, 32'd1});
    cycle();

    // Reset while holding a stalled grant with a full response.
    reset_dut(0);
    rsp_ready = 1'b0;
    set0(4'd0, 32'd1, 32'd2);
    cycle();
    set0(4'd0, 32'd3, 32'd4);
    set1(4'd1, 32'd8, 32'd1);
    repeat (2) cycle();
    reset_dut(1);
    clr_hist();
    rsp_ready = 1'b1;
    repeat (4) cycle();
    chk("rst_first_ids", {id_cnt[7:0], id_hist[7:0]}, {8'd2, 8'b01});

    // Fixed priority instance.
    sel = 1; m_rr = 1'b0;
    v0 = 1'b0; v1 = 1'b0;
    reset_dut(0);
    clr_hist();
    rsp_ready = 1'b1;
    set1(4'd4, 32'd0, 32'd0);
    for (int i = 0; i < 4; i++) begin
      set0(4'd0, 32'(i), 32'd1);
      cycle();
    end
    repeat (3) cycle();
    chk("fixed_ids", {id_cnt[7:0], id_hist[7:0]}, {8'd5, 8'b00001});

    // Random traffic on both instances.
    for (int s = 0; s < 2; s++) begin
      sel = s; m_rr = (s == 0);
      v0 = 1'b0; v1 = 1'b0;
      reset_dut(0);
      for (int i = 0; i < 400; i++) begin
        if (!v0 && $urandom_range(0, 99) < 55) set0(rnd_op(), rnd_val(), rnd_val());
        if (!v1 && $urandom_range(0, 99) < 55) set1(rnd_op(), rnd_val(), rnd_val());
        rsp_ready = ($urandom_range(0, 99) < 60);
        cycle();
      end
      rsp_ready = 1'b1;
      for (int i = 0; i < 30 && (v0 || v1 || exp_q.size() != 0); i++) cycle();
      chk("drain_empty", 72'(exp_q.size()), 72'd0);
      chk("drain_idle", {v0, v1}, 72'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
